// File: rtl/psum_accum_buffer.sv
// psum_accum_buffer: collects psum vectors from the systolic array and accumulates
// them per output address in an on-chip buffer. A 2-stage read-modify-write
// pipeline with same-address forwarding lets back-to-back accumulates to one entry
// stay exact. After a pass, the buffer is drained over a valid/ready stream.
// Build option: define PSUM_SATURATE_EN to make each lane's add saturate to the
// signed ACC_WIDTH range. Without it, lanes wrap modulo 2**ACC_WIDTH.

module psum_accum_buffer #(
    parameter int ARRAY_DIM  = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           acc_enable,
    input  logic                           acc_clear,
    input  logic [ADDR_WIDTH-1:0]          acc_addr,
    input  logic [ARRAY_DIM*ACC_WIDTH-1:0] acc_data,
    input  logic                           drain_start,
    input  logic [ADDR_WIDTH:0]            drain_count,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ADDR_WIDTH-1:0]          out_addr,
    output logic [ARRAY_DIM*ACC_WIDTH-1:0] out_data,
    output logic                           busy,
    output logic                           drain_done,
    output logic                           err
);

    localparam int VEC_W = ARRAY_DIM * ACC_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_BEAT  = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_WB,
        DRAIN_RD,
        DRAIN_OUT
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH:0]     beats_q, beats_d;
    logic [ADDR_WIDTH:0]     count_clamped;
    logic                    drain_done_q, drain_done_d;
    logic                    err_q;

    logic [VEC_W-1:0]        mem [DEPTH];
    logic [VEC_W-1:0]        rd_q;
    logic [VEC_W-1:0]        s1_data_q;
    logic [VEC_W-1:0]        fwd_data_q;
    logic [VEC_W-1:0]        operand;
    logic [VEC_W-1:0]        new_vec;
    logic                    s1_valid_q, s1_clear_q, fwd_hit_q, fwd_hit_d;
    logic [ADDR_WIDTH-1:0]   s1_addr_q, rd_addr;
    logic                    acc_take, rd_en;

    // One lane of the accumulate: signed add, wrapping or saturating by build option.
    function automatic logic [ACC_WIDTH-1:0] lane_add(input logic [ACC_WIDTH-1:0] a,
                                                      input logic [ACC_WIDTH-1:0] b);
        logic [ACC_WIDTH-1:0] res;
`ifdef PSUM_SATURATE_EN
        logic [ACC_WIDTH:0] sum;
        sum = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
        res = sum[ACC_WIDTH-1:0];
        if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1])
            res = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                 : {1'b0, {(ACC_WIDTH-1){1'b1}}};
`else
        res = a + b;
`endif
        return res;
    endfunction

    // Vectors are only taken while IDLE; anything arriving during a drain is dropped.
    assign acc_take  = acc_enable && (state_q == IDLE);
    // Stage 1 of a write that hits the address stage 2 is writing this very edge.
    assign fwd_hit_d = acc_take && s1_valid_q && (acc_addr == s1_addr_q);
    // The single read port serves the drain in DRAIN_RD and the accumulator otherwise.
    assign rd_en     = acc_take || (state_q == DRAIN_RD);
    assign rd_addr   = (state_q == DRAIN_RD) ? addr_q : acc_addr;
    assign count_clamped = (drain_count > DEPTH_CNT) ? DEPTH_CNT : drain_count;

    // Stage 2 datapath: pick forwarded or RAM operand, then overwrite or add per lane.
    always_comb begin
        operand = fwd_hit_q ? fwd_data_q : rd_q;
        new_vec = '0;
        for (int k = 0; k < ARRAY_DIM; k++) begin
            new_vec[k*ACC_WIDTH +: ACC_WIDTH] = s1_clear_q
                ? s1_data_q[k*ACC_WIDTH +: ACC_WIDTH]
                : lane_add(operand[k*ACC_WIDTH +: ACC_WIDTH], s1_data_q[k*ACC_WIDTH +: ACC_WIDTH]);
        end
    end

    // Buffer storage plus the wide datapath registers that feed and bypass it.
    // NOTE: memories and pure datapath registers get no reset; they are qualified by
    // reset valid bits, and the buffer contents must survive a reset anyway.
    always_ff @(posedge clk) begin
        if (s1_valid_q) mem[s1_addr_q] <= new_vec;
        if (rd_en)      rd_q           <= mem[rd_addr];
        if (acc_take)   s1_data_q      <= acc_data;
        fwd_data_q <= new_vec;
    end

    // Stage 1 control registers and the forwarding flag.
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_clear_q <= 1'b0;
            s1_addr_q  <= '0;
            fwd_hit_q  <= 1'b0;
        end else begin
            s1_valid_q <= acc_take;
            fwd_hit_q  <= fwd_hit_d;
            if (acc_take) begin
                s1_clear_q <= acc_clear;
                s1_addr_q  <= acc_addr;
            end
        end
    end

    // Drain FSM next-state and beat bookkeeping.
    // NOTE: every variable gets a default at the top so no path leaves one unassigned
    // and infers a latch.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        beats_d      = beats_q;
        drain_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (drain_start) begin
                    state_d = WAIT_WB;
                    beats_d = count_clamped;
                    addr_d  = '0;
                end
            end
            WAIT_WB: begin
                if (beats_q == '0) begin
                    state_d      = IDLE;
                    drain_done_d = 1'b1;
                end else begin
                    state_d = DRAIN_RD;
                end
            end
            DRAIN_RD: state_d = DRAIN_OUT;
            DRAIN_OUT: begin
                if (out_ready) begin
                    if (beats_q > ONE_BEAT) begin
                        state_d = DRAIN_RD;
                        addr_d  = addr_q + 1'b1;
                        beats_d = beats_q - ONE_BEAT;
                    end else begin
                        state_d      = IDLE;
                        beats_d      = '0;
                        drain_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Drain FSM state, beat counters, done pulse and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            beats_q      <= '0;
            drain_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            beats_q      <= beats_d;
            drain_done_q <= drain_done_d;
            err_q        <= err_q | (acc_enable && (state_q != IDLE));
        end
    end

    assign out_valid  = (state_q == DRAIN_OUT);
    assign out_addr   = addr_q;
    assign out_data   = out_valid ? rd_q : '0;
    assign busy       = (state_q != IDLE) || s1_valid_q;
    assign drain_done = drain_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_psum_accum_buffer.sv
// tb_psum_accum_buffer: directed stimulus with a scoreboard. The stimulus process
// pushes the expected drain beats into a queue; a negedge monitor pops and compares
// each beat the DUT transfers and checks that stalled beats hold steady.

module tb_psum_accum_buffer;

    localparam int AW    = 10;
    localparam int LANES = 16;
    localparam int AWID  = 32;
    localparam int VEC_W = LANES * AWID;

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [VEC_W-1:0] data;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             acc_enable, acc_clear;
    logic [AW-1:0]    acc_addr;
    logic [VEC_W-1:0] acc_data;
    logic             drain_start;
    logic [AW:0]      drain_count;
    logic             out_valid, out_ready;
    logic [AW-1:0]    out_addr;
    logic [VEC_W-1:0] out_data;
    logic             busy, drain_done, err;

    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;
    int beat_idx = 0;
    bit addr_only = 1'b0;
    bit stalled = 1'b0;
    logic [AW-1:0]    held_addr;
    logic [VEC_W-1:0] held_data;
    beat_t exp_q[$];
    logic [VEC_W-1:0] exp_entry[8];

    psum_accum_buffer #(.ARRAY_DIM(LANES), .ACC_WIDTH(AWID), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .acc_enable(acc_enable), .acc_clear(acc_clear), .acc_addr(acc_addr), .acc_data(acc_data),
        .drain_start(drain_start), .drain_count(drain_count),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
        .busy(busy), .drain_done(drain_done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VEC_W-1:0] vec_all(input logic [AWID-1:0] v);
        logic [VEC_W-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*AWID +: AWID] = v;
        return r;
    endfunction

    function automatic logic [VEC_W-1:0] vec_ramp(input int base);
        logic [VEC_W-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*AWID +: AWID] = AWID'(base + k);
        return r;
    endfunction

    task automatic acc(input int addr, input bit clr, input logic [VEC_W-1:0] v);
        acc_enable = 1'b1;
        acc_clear  = clr;
        acc_addr   = AW'(addr);
        acc_data   = v;
        tick();
    endtask

    task automatic acc_idle();
        acc_enable = 1'b0;
        acc_clear  = 1'b0;
        tick();
    endtask

    task automatic expect_entries(input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.addr = AW'(i);
            b.data = exp_entry[i];
            exp_q.push_back(b);
        end
    endtask

    // mode 0: ready high; 1: ready toggles every two cycles; 2: stall, inject acc, then ready.
    task automatic run_drain(input int cnt, input int mode);
        int  done0;
        bit  got;
        done0 = done_seen;
        got   = 1'b0;
        drain_count = (AW + 1)'(cnt);
        drain_start = 1'b1;
        out_ready   = (mode == 0);
        tick();
        drain_start = 1'b0;
        if (mode == 2) begin
            for (int c = 0; c < 20 && !out_valid; c++) tick();
            check("inject_in_drain_out", out_valid, 1);
            acc(7, 1'b1, vec_all(32'h0000_DEAD));
            acc_enable = 1'b0;
            acc_clear  = 1'b0;
            check("err_set_in_drain", err, 1);
            out_ready = 1'b1;
        end
        for (int c = 0; c < 3000 && !got; c++) begin
            if (mode == 1) out_ready = c[1];
            tick();
            got = (done_seen != done0);
        end
        check("drain_done_seen", got, 1);
        repeat (3) tick();
        check("drain_done_once", done_seen - done0, 1);
        check("scoreboard_drained", exp_q.size(), 0);
        out_ready = 1'b0;
    endtask

    // Monitor: compare transferred beats against the queue and check stall stability.
    always @(negedge clk) begin
        beat_t b;
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (drain_done) done_seen++;
            if (stalled) begin
                check("stall_valid_held", out_valid, 1);
                check("stall_addr_held", out_addr, held_addr);
                check("stall_data_held", out_data, held_data);
            end
            stalled = 1'b0;
            if (out_valid && out_ready) begin
                if (addr_only) begin
                    check("clamp_beat_addr", out_addr, beat_idx);
                    beat_idx++;
                end else if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got beat at addr %0d expected none", out_addr);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_addr", out_addr, b.addr);
                    check("beat_data", out_data, b.data);
                end
            end else if (out_valid) begin
                stalled   = 1'b1;
                held_addr = out_addr;
                held_data = out_data;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VEC_W-1:0] v6, add6;
        rst_n = 1'b0;
        acc_enable = 1'b0; acc_clear = 1'b0; acc_addr = '0; acc_data = '0;
        drain_start = 1'b0; drain_count = '0; out_ready = 1'b0;
        repeat (2) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_drain_done", drain_done, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        tick();

        // Entry 6 exercises positive and negative overflow on lanes 0 and 1.
        v6 = vec_ramp(600);
        v6[0 +: AWID]    = 32'h7FFF_FFF0;
        v6[AWID +: AWID] = 32'h8000_0010;
        add6 = '0;
        add6[0 +: AWID]    = 32'h0000_0020;
        add6[AWID +: AWID] = 32'hFFFF_FFE0;

        acc(0, 1'b1, vec_ramp(100));
        acc(2, 1'b1, vec_ramp(200));
        acc(4, 1'b1, vec_ramp(400));
        acc(7, 1'b1, vec_ramp(700));
        acc(1, 1'b1, vec_ramp(1000));
        acc(6, 1'b1, v6);
        acc_idle();
        acc(1, 1'b0, vec_all(-32'sd1000));
        acc(6, 1'b0, add6);
        acc_idle();
        // Clear without enable must be ignored.
        acc_enable = 1'b0; acc_clear = 1'b1; acc_addr = AW'(2); acc_data = '0;
        tick();
        acc_clear = 1'b0;
        // Entry 5: clear to 16 then four spaced +16s.
        acc(5, 1'b1, vec_all(16));
        for (int i = 0; i < 4; i++) begin
            acc_idle();
            acc(5, 1'b0, vec_all(16));
        end
        // Entry 3: back-to-back 1(clear), 2, 3, 4 relies on forwarding.
        acc(3, 1'b1, vec_all(1));
        acc(3, 1'b0, vec_all(2));
        acc(3, 1'b0, vec_all(3));
        acc(3, 1'b0, vec_all(4));
        check("busy_write_in_flight", busy, 1);
        acc_idle();
        acc_idle();
        check("idle_not_busy", busy, 0);

        exp_entry[0] = vec_ramp(100);
        exp_entry[1] = vec_ramp(0);
        exp_entry[2] = vec_ramp(200);
        exp_entry[3] = vec_all(10);
        exp_entry[4] = vec_ramp(400);
        exp_entry[5] = vec_all(80);
        exp_entry[6] = vec_ramp(600);
`ifdef PSUM_SATURATE_EN
        exp_entry[6][0 +: AWID]    = 32'h7FFF_FFFF;
        exp_entry[6][AWID +: AWID] = 32'h8000_0000;
`else
        exp_entry[6][0 +: AWID]    = 32'h8000_0010;
        exp_entry[6][AWID +: AWID] = 32'h7FFF_FFF0;
`endif
        exp_entry[7] = vec_ramp(700);

        // Four beats with a stalling consumer.
        expect_entries(4);
        run_drain(4, 1);
        check("err_clear_before_inject", err, 0);

        // acc_enable during DRAIN_OUT is dropped and flagged.
        expect_entries(2);
        run_drain(2, 2);
        check("err_sticky", err, 1);

        // Zero-length drain: done pulse, no beats.
        run_drain(0, 0);

        // Full readback; entry 7 must not show the dropped write.
        expect_entries(8);
        run_drain(8, 0);

        // Oversized count clamps to the full depth without wrapping.
        addr_only = 1'b1;
        beat_idx  = 0;
        run_drain(2047, 0);
        addr_only = 1'b0;
        check("clamp_beat_count", beat_idx, 1024);

        // Reset in the middle of a drain.
        out_ready   = 1'b0;
        drain_count = (AW + 1)'(8);
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        for (int c = 0; c < 20 && !out_valid; c++) tick();
        check("pre_reset_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_err", err, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        expect_entries(8);
        run_drain(8, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
